// File: rtl/lfu_finder_pkg.sv
// Shared constants for the 4-entry LFU replacement finder.
package lfu_finder_pkg;
  localparam int NUM_BUF   = 4;
  localparam int IDX_W     = 2;
  localparam int CNT_W_DEF = 4;
  localparam int SEQ_W     = NUM_BUF * IDX_W;

  // Recency list after reset: slot 0 (LRU) holds buffer 0, slot 3 (MRU) holds buffer 3.
  localparam logic [SEQ_W-1:0] REF_SEQ_RST = 8'b11_10_01_00;
endpackage

// File: rtl/lfu_finder_min_sel.sv
// Victim picker: smallest count wins; ties go to the entry nearest the LRU end of ref_seq.
module lfu_min_sel
  import lfu_finder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [NUM_BUF-1:0][CNT_W-1:0] cnt_i,
  input  logic [NUM_BUF-1:0][IDX_W-1:0] seq_i,
  output logic [IDX_W-1:0]              victim_o
);

  logic [CNT_W-1:0] best_cnt;

  // Walk from LRU to MRU; strict less-than keeps the earlier (older) entry on a tie.
  always_comb begin
    victim_o = seq_i[0];
    best_cnt = cnt_i[seq_i[0]];
    for (int k = 1; k < NUM_BUF; k++) begin
      if (cnt_i[seq_i[k]] < best_cnt) begin
        victim_o = seq_i[k];
        best_cnt = cnt_i[seq_i[k]];
      end
    end
  end

endmodule

// File: rtl/lfu_finder.sv
// LFU replacement finder: per-buffer use counters with aging, recency list, registered victim.
module lfu_finder
  import lfu_finder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_buf_req,
  input  logic [IDX_W-1:0] ref_buf_numbr,
  output logic [IDX_W-1:0] buf_num_replc
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_BUF-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_BUF-1:0][IDX_W-1:0] seq_q, seq_d;
  logic [IDX_W-1:0]              replc_q, vic_d;
  logic [IDX_W-1:0]              tgt;
  int                            pos;

  always_comb begin
    cnt_d = cnt_q;
    seq_d = seq_q;
    pos   = 0;
    tgt   = new_buf_req ? replc_q : ref_buf_numbr;

    if (new_buf_req) begin
      cnt_d[tgt] = CNT_W'(1);
    end else if (cnt_q[tgt] == CNT_MAX) begin
      // Saturated: halve every counter so relative frequency survives, then count this use.
      for (int i = 0; i < NUM_BUF; i++) cnt_d[i] = cnt_q[i] >> 1;
      cnt_d[tgt] = (cnt_q[tgt] >> 1) + CNT_W'(1);
    end else begin
      cnt_d[tgt] = cnt_q[tgt] + CNT_W'(1);
    end

    for (int i = 0; i < NUM_BUF; i++) begin
      if (seq_q[i] == tgt) pos = i;
    end
    // Entries above the target slide one slot toward LRU; target lands in MRU.
    for (int k = 0; k < NUM_BUF - 1; k++) begin
      seq_d[k] = (k < pos) ? seq_q[k] : seq_q[k+1];
    end
    seq_d[NUM_BUF-1] = tgt;
  end

  lfu_min_sel #(.CNT_W(CNT_W)) u_min_sel (
    .cnt_i    (cnt_d),
    .seq_i    (seq_d),
    .victim_o (vic_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      seq_q   <= REF_SEQ_RST;
      replc_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      replc_q <= vic_d;
    end
  end

  assign buf_num_replc = replc_q;

endmodule

// File: tb/tb_lfu_finder.sv
// Scoreboard bench for lfu_finder: directed cases plus randomized traffic vs a queue-based model.
module tb_lfu_finder;
  localparam int MAXC = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_buf_req = 1'b0;
  logic [1:0] ref_buf_numbr = 2'bxx;
  logic [1:0] buf_num_replc;

  int    checks = 0;
  int    errors = 0;
  int    exp_q[$];
  string name_q[$];

  int m_cnt[4];
  int m_seq[$];
  int m_vic;

  lfu_finder #(.CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .new_buf_req   (new_buf_req),
    .ref_buf_numbr (ref_buf_numbr),
    .buf_num_replc (buf_num_replc)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_seq = {0, 1, 2, 3};
    m_vic = 0;
  endtask

  task automatic m_apply(input bit req, input int r);
    int t;
    t = req ? m_vic : r;
    if (req) m_cnt[t] = 1;
    else if (m_cnt[t] == MAXC) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = m_cnt[i] / 2;
      m_cnt[t] = m_cnt[t] + 1;
    end else m_cnt[t] = m_cnt[t] + 1;
    for (int k = 0; k < m_seq.size(); k++) begin
      if (m_seq[k] == t) begin
        m_seq.delete(k);
        break;
      end
    end
    m_seq.push_back(t);
    m_vic = m_seq[0];
    for (int k = 1; k < 4; k++) if (m_cnt[m_seq[k]] < m_cnt[m_vic]) m_vic = m_seq[k];
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    new_buf_req = 1'($urandom_range(1));
    ref_buf_numbr = 2'bxx;
    m_reset();
    exp_q.push_back(0);
    name_q.push_back(nm);
  endtask

  // exp < 0 means take the expectation from the model.
  task automatic step(input bit req, input int r, input int exp, input string nm);
    @(negedge clk);
    rst_n = 1'b1;
    new_buf_req = req;
    ref_buf_numbr = 2'(r);
    m_apply(req, r);
    exp_q.push_back(exp >= 0 ? exp : m_vic);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    int    e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (buf_num_replc !== 2'(e)) begin
          errors++;
          $display("FAIL %s: buf_num_replc got %0d expected %0d", nm, buf_num_replc, e);
        end
      end
    end
  end

  initial begin : driver
    int mixed[20] = '{0,1,2,3,1,0,2,0,0,0,0,2,0,3,1,0,1,2,3,0};
    int budget;

    do_reset("reset");

    step(0, 0, -1, "basic_r0");
    step(0, 1, -1, "basic_r1");
    step(0, 2, -1, "basic_r2");
    step(0, 3, 0, "basic_1111");
    step(0, 1, 0, "basic_1211");
    step(0, 0, 2, "basic_2211");
    step(0, 2, 3, "basic_2221");

    do_reset("reset_aging");
    for (int i = 0; i < 16; i++) step(0, 0, 1, $sformatf("aging_%0d", i + 1));

    do_reset("reset_replace");
    for (int i = 0; i < 4; i++) step(0, i, -1, "replace_prep");
    step(1, 2, 1, "replace");
    step(1, 3, -1, "replace_b2b");

    do_reset("reset_mid_prep");
    for (int i = 0; i < 20; i++)
      step(($urandom_range(7) == 0), $urandom_range(3), -1, "mid_prep");
    do_reset("reset_mid");
    step(0, 3, 0, "post_reset_ref3");

    do_reset("reset_mixed");
    foreach (mixed[i]) step(0, mixed[i], -1, $sformatf("mixed_%0d", i));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) do_reset("rand_reset");
      else if ($urandom_range(99) < 60)
        step(($urandom_range(7) == 0), ($urandom_range(3) == 0) ? $urandom_range(3) : 2, -1, "rand_skew");
      else
        step(($urandom_range(7) == 0), $urandom_range(3), -1, "rand");
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfu_finder.md
# lfu_finder

Least-frequently-used replacement finder for a 4-entry buffer pool. One buffer reference is presented every clock. The block keeps a per-buffer use counter and a recency order, and continuously reports which buffer should be replaced next. It sits beside the buffer manager, which reads `buf_num_replc` when it needs a victim and pulses `new_buf_req` when it reloads that victim.

## Interface
- `CNT_W`, default 4: width of each use counter; maximum count 2^CNT_W−1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset; one clock, synchronous, active-low reset `rst_n`.
- `new_buf_req` in 1: the buffer currently named by `buf_num_replc` is being reloaded this cycle.
- `ref_buf_numbr` in 2: index of the buffer referenced this cycle; treated as valid every cycle outside reset.
- `buf_num_replc` out 2: registered index of the replacement victim.

## Operation
- State:
  - four counters `buf_0_cnt`..`buf_3_cnt`, each CNT_W bits;
  - `ref_seq[7:0]`, a recency list of four 2-bit indices; `[1:0]` is the LRU entry, `[7:6]` is the MRU entry; always a permutation of 0..3.
- Reset (`rst_n`=0 at an edge):
  - all counters = 0;
  - `ref_seq` = {3,2,1,0}, so buffer 0 is LRU;
  - `buf_num_replc` = 0;
  - inputs are ignored and may be X.
- Reference cycle (`new_buf_req`=0), with r = `ref_buf_numbr`:
  - if `buf_r_cnt` < max, increment it;
  - if `buf_r_cnt` == max, age first: shift all four counters right by 1, then increment the aged `buf_r_cnt`;
  - move r to the MRU slot of `ref_seq`, keeping the relative order of the other three.
- Replace cycle (`new_buf_req`=1), with v = current `buf_num_replc`:
  - `buf_v_cnt` := 1;
  - v moves to MRU;
  - `ref_buf_numbr` is ignored for that cycle; no other counter changes.
- Victim selection, combinational on the next-state values:
  - pick the buffer with the minimum count;
  - on a tie, pick the tied buffer closest to the LRU end of next-state `ref_seq`;
  - the result is registered into `buf_num_replc`.
- Counters never wrap; aging is the only decrement path.

## Timing
- Latency is 1 cycle. The edge that applies a reference or replace also loads `buf_num_replc` with the victim for the updated state, so the value is visible right after that edge.
- Reset asserted mid-operation clears everything at the next edge. The first reference is accepted on the first edge with `rst_n`=1.
- `new_buf_req` is a single-cycle strobe; back-to-back strobes are legal, each acting on the victim index from the previous cycle.
- No handshake, no stall; one update per clock.

## Structure
- Shared package: `NUM_BUF`=4, index width 2, default `CNT_W`, and the reset `ref_seq` constant.
- One natural sub-module, `lfu_min_sel`: it takes 4 counts plus `ref_seq` and returns the victim index (min-compare tree with recency tie-break). The top level holds the counters, aging, recency update and output register.
- Total RTL is roughly 150–250 lines.

## Test plan
- **Reset:** hold `rst_n`=0 one cycle with X on `ref_buf_numbr` → all counters 0, `ref_seq`=8'b11_10_01_00, `buf_num_replc`=0.
- **Basic frequency/recency** (refs start at the first cycle after reset, `new_buf_req`=0):
  - refs 0,1,2,3 → counts 1,1,1,1, `buf_num_replc`=0;
  - then ref 1 → counts 1,2,1,1, still 0;
  - then ref 0 → counts 2,2,1,1, victim 2;
  - then ref 2 → counts 2,2,2,1, victim 3.
- **Aging:** from reset, ref 0 sixteen times → after the 15th, `buf_0_cnt`=15; after the 16th, `buf_0_cnt`=8 and others 0; `buf_num_replc`=1 throughout from the first ref.
- **Replace:** from counts 1,1,1,1 with victim 0, pulse `new_buf_req` with `ref_buf_numbr`=2 → `buf_0_cnt`=1, `buf_2_cnt` unchanged at 1, 0 becomes MRU, `buf_num_replc`=1.
- **Mid-run reset:** after about 20 mixed refs, assert `rst_n`=0 one cycle → same values as the reset case; the next ref 3 gives victim 0.
- **Long mixed sequence:** 0,1,2,3,1,0,2,0,0,0,0,2,0,3,1,0,1,2,3,0,… → a scoreboard model of the counters, aging and tie-break matches `buf_num_replc` every cycle.
